dot_operand_loader: RTL and testbench
=====================================

# dot_operand_loader

Operand-staging front end for the 32-lane 8-bit dot-product engine. It accepts a byte stream over a valid/ready handshake and assembles operand vectors `a` and `b`. It then fires a one-cycle start to the engine, waits for completion and captures the 16-bit result. The result goes out on a valid/ready handshake. The block sits directly upstream of the dot-product engine and owns its `start`, `a` and `b` inputs.

## Interface
- `VEC_LEN`, 32, elements per operand vector; frame length is 2*VEC_LEN bytes.
- `DATA_W`, 8, element width.
- `TIMEOUT_CYC`, 64, completion watchdog limit. Used only when `DOT_LOADER_TIMEOUT_EN` is defined.

- `clk`  in  1  sole clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  input byte valid.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `in_data`  in  DATA_W  operand byte.
- `in_last`  in  1  marks the final byte of a frame.
- `dot_a`  out  DATA_W x VEC_LEN  operand vector a, to engine `a[0:31]`.
- `dot_b`  out  DATA_W x VEC_LEN  operand vector b, to engine `b[0:31]`.
- `dot_start`  out  1  one-cycle start pulse to the engine.
- `dot_done`  in  1  engine completion level.
- `dot_c`  in  16  engine result.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts the result.
- `res_data`  out  16  captured result.
- `err`  out  1  one-cycle pulse on a framing error or a timeout.
- `busy`  out  1  high in FIRE, WAIT and HOLD.

## Operation
- The FSM has five states: LOAD_A, LOAD_B, FIRE, WAIT and HOLD. Reset state is LOAD_A.
- `in_ready` is 1 in LOAD_A and LOAD_B, and 0 otherwise. It is decoded combinationally from state.
- A 7-bit byte index `k` counts from 0 and increments on each accepted byte (`in_valid && in_ready`).
  - Bytes with k < VEC_LEN are written to `dot_a[k]`.
  - All other bytes are written to `dot_b[k-VEC_LEN]`.
  - State moves from LOAD_A to LOAD_B after byte VEC_LEN-1 is accepted.
- **Framing check:** `in_last` must be high on byte 2*VEC_LEN-1 and low on every other byte.
  - `in_last` high on an earlier byte: pulse `err`, reset `k` to 0, return to LOAD_A, no start. The byte is consumed.
  - `in_last` low on byte 2*VEC_LEN-1: pulse `err`, reset `k` to 0, return to LOAD_A, no start.
  - Partially written `dot_a`/`dot_b` contents are don't-care until the next valid frame completes.
- On a correct final byte, the FSM enters FIRE. In FIRE, `dot_start` = 1 for exactly one cycle, then the FSM enters WAIT.
- **WAIT:** a 1-bit `done_q` register tracks `dot_done`. Completion is the rising edge, `dot_done && !done_q`.
  - `done_q` is sampled in every state, so a `done` level already high when WAIT is entered does not count as completion.
  - The engine must return `dot_done` low between operations.
- On completion, `res_data` <= `dot_c` and the FSM enters HOLD.
- **HOLD:** `res_valid` = 1. On `res_valid && res_ready`, the FSM returns to LOAD_A with `k` = 0.
- `dot_a`/`dot_b` are stable from the final-byte accept until the next frame's first accepted byte.
- `res_data` is stable while `res_valid` is high.
- Reset values: `dot_a`/`dot_b` all 0, `dot_start` 0, `res_valid` 0, `res_data` 0, `err` 0, `busy` 0, `in_ready` 1, `k` 0, `done_q` 0.

## Timing
- The last byte is accepted in cycle N. `dot_start` = 1 in cycle N+1.
- A `dot_done` rising edge sampled in cycle M gives `res_valid` = 1 from cycle M+1.
- A result handshake in cycle H gives `in_ready` = 1 in cycle H+1. There is no input bubble beyond that one cycle.
- `err` is asserted in the cycle after the offending byte is accepted.
- Asserting `rst_n` low in any state clears everything asynchronously:
  - A partial frame is lost.
  - A start already issued is forgotten.
  - Any later `dot_done` edge is ignored unless the FSM is in WAIT.
- `in_data` and `in_last` are ignored when `in_ready` = 0.

## Configuration
- `DOT_LOADER_TIMEOUT_EN` defined:
  - An 8-bit counter clears on WAIT entry and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYC without a completion edge, then:
    - `res_data` <= 16'h0000,
    - `err` pulses,
    - the FSM enters HOLD, which proceeds normally.
- `DOT_LOADER_TIMEOUT_EN` undefined: there is no counter, and WAIT persists until a completion edge or reset.

## Test plan
- **Reset:** hold `rst_n` low for 3 cycles, then release. Expect `in_ready` = 1, `res_valid` = 0, `dot_start` = 0, `err` = 0, `busy` = 0 and all `dot_a`/`dot_b` = 0.
- **Nominal frame:**
  - Stimulus: 64 bytes back-to-back, a[k] = 1 and b[k] = 2, `in_last` on byte 63. The engine model raises `dot_done` 3 cycles after start with `dot_c` = 16'd64.
  - Expect `dot_start` exactly one cycle after the last accept, `res_valid` with `res_data` = 64, `err` never high.
- **Backpressure:** same frame, `res_ready` held low for 10 cycles. Expect `res_valid` and `res_data` held, `in_ready` = 0, `dot_a`/`dot_b` unchanged. After the handshake, `in_ready` = 1 the next cycle.
- **Early last:** `in_last` on byte 10. Expect an `err` pulse and no `dot_start`. A following correct frame with a[k] = k and b[k] = 1 produces `res_data` = `dot_c` from the model (496).
- **Missing last:** 64 bytes with `in_last` never high. Expect an `err` pulse after byte 63, no `dot_start`, and return to LOAD_A.
- **Timeout (macro defined):** `dot_done` never rises. Expect an `err` pulse and `res_valid` with `res_data` = 0 after 64 WAIT cycles. Without the macro, `res_valid` stays 0 for 1000 cycles.

Source files
------------

// File: rtl/dot_operand_loader.sv
// dot_operand_loader: byte-stream operand stager for the 32-lane dot-product engine.
// Bytes 0..VEC_LEN-1 of a frame fill vector a and the rest fill vector b. A
// correctly framed final byte fires a one-cycle start. The loader then waits for
// the engine's done rising edge and holds the result on a valid/ready port.
// Optional feature: define DOT_LOADER_TIMEOUT_EN to add a completion watchdog.
// A watchdog expiry returns a zero result and pulses err.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. The producer holds valid and its payload stable until that edge. ready
// may change freely. in_ready is decoded from state only.
module dot_operand_loader #(
  parameter int VEC_LEN = 32,
  parameter int DATA_W  = 8
`ifdef DOT_LOADER_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 64
`endif
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DATA_W-1:0]                in_data,
  input  logic                             in_last,
  output logic [VEC_LEN-1:0][DATA_W-1:0]   dot_a,
  output logic [VEC_LEN-1:0][DATA_W-1:0]   dot_b,
  output logic                             dot_start,
  input  logic                             dot_done,
  input  logic [15:0]                      dot_c,
  output logic                             res_valid,
  input  logic                             res_ready,
  output logic [15:0]                      res_data,
  output logic                             err,
  output logic                             busy,
  output logic [2:0]                       dbg_state
);

  localparam int         IDX_W     = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam logic [6:0] LAST_A    = 7'(VEC_LEN - 1);
  localparam logic [6:0] LAST_B    = 7'(2 * VEC_LEN - 1);
  localparam logic [6:0] VEC_LEN_K = 7'(VEC_LEN);

  typedef enum logic [2:0] {
    ST_LOAD_A = 3'd0,
    ST_LOAD_B = 3'd1,
    ST_FIRE   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_HOLD   = 3'd4
  } state_t;

  state_t                           state_q, state_d;
  logic [6:0]                       k_q, k_d;
  logic [VEC_LEN-1:0][DATA_W-1:0]   a_q, a_d;
  logic [VEC_LEN-1:0][DATA_W-1:0]   b_q, b_d;
  logic                             start_q, start_d;
  logic                             done_q;
  logic                             res_valid_q, res_valid_d;
  logic [15:0]                      res_data_q, res_data_d;
  logic                             err_q, err_d;
  logic                             accept;
  logic                             done_rise;
  logic [IDX_W-1:0]                 a_idx;
  logic [IDX_W-1:0]                 b_idx;
`ifdef DOT_LOADER_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);
  logic [7:0]                       to_cnt_q, to_cnt_d;
`endif

  assign in_ready  = (state_q == ST_LOAD_A) || (state_q == ST_LOAD_B);
  assign busy      = (state_q == ST_FIRE) || (state_q == ST_WAIT) || (state_q == ST_HOLD);
  assign accept    = in_valid && in_ready;
  assign done_rise = dot_done && !done_q;
  assign a_idx     = k_q[IDX_W-1:0];
  assign b_idx     = IDX_W'(k_q - VEC_LEN_K);

  assign dot_a     = a_q;
  assign dot_b     = b_q;
  assign dot_start = start_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign err       = err_q;
  assign dbg_state = state_q;

  // Next-state, byte steering, framing check and result capture.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    a_d         = a_q;
    b_d         = b_q;
    start_d     = 1'b0;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    err_d       = 1'b0;
`ifdef DOT_LOADER_TIMEOUT_EN
    to_cnt_d    = to_cnt_q;
`endif
    case (state_q)
      ST_LOAD_A: begin
        if (accept) begin
          a_d[a_idx] = in_data;
          if (in_last) begin
            // Early end of frame: the byte is consumed and the frame is dropped.
            err_d = 1'b1;
            k_d   = '0;
          end else begin
            k_d = k_q + 7'd1;
            if (k_q == LAST_A) state_d = ST_LOAD_B;
          end
        end
      end
      ST_LOAD_B: begin
        if (accept) begin
          b_d[b_idx] = in_data;
          k_d        = '0;
          if (k_q == LAST_B) begin
            if (in_last) begin
              state_d = ST_FIRE;
              start_d = 1'b1;
            end else begin
              err_d   = 1'b1;
              state_d = ST_LOAD_A;
            end
          end else if (in_last) begin
            err_d   = 1'b1;
            state_d = ST_LOAD_A;
          end else begin
            k_d = k_q + 7'd1;
          end
        end
      end
      ST_FIRE: begin
        state_d = ST_WAIT;
`ifdef DOT_LOADER_TIMEOUT_EN
        to_cnt_d = '0;
`endif
      end
      ST_WAIT: begin
        // Only a fresh rising edge counts; a level left high is not a completion.
        if (done_rise) begin
          res_data_d  = dot_c;
          res_valid_d = 1'b1;
          state_d     = ST_HOLD;
        end
`ifdef DOT_LOADER_TIMEOUT_EN
        else if (to_cnt_q == TO_LAST) begin
          res_data_d  = 16'h0000;
          res_valid_d = 1'b1;
          err_d       = 1'b1;
          state_d     = ST_HOLD;
        end else begin
          to_cnt_d = to_cnt_q + 8'd1;
        end
`endif
      end
      ST_HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          k_d         = '0;
          state_d     = ST_LOAD_A;
        end
      end
      default: begin
        state_d = ST_LOAD_A;
        k_d     = '0;
      end
    endcase
  end

  // State and datapath registers; done_q samples dot_done in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_LOAD_A;
      k_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      err_q       <= 1'b0;
`ifdef DOT_LOADER_TIMEOUT_EN
      to_cnt_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      a_q         <= a_d;
      b_q         <= b_d;
      start_q     <= start_d;
      done_q      <= dot_done;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      err_q       <= err_d;
`ifdef DOT_LOADER_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_dot_operand_loader.sv
// tb_dot_operand_loader: randomized frames against a reference model of the
// operand loader. The reference model keeps the sent operand bytes and computes
// their dot product. A small engine model drives the loader's done/c inputs.
`timescale 1ns/1ps
module tb_dot_operand_loader;

  localparam int VEC_LEN = 32;
  localparam int DATA_W  = 8;
  localparam int NB      = 2 * VEC_LEN;

  // ---------------- clock / reset / signals ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic res_ready = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic dot_done = 1'b0;
  logic [15:0] dot_c = '0;
  logic in_ready, dot_start, res_valid, err, busy;
  logic [VEC_LEN-1:0][DATA_W-1:0] dot_a, dot_b;
  logic [15:0] res_data;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  dot_operand_loader #(.VEC_LEN(VEC_LEN), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .dot_a(dot_a), .dot_b(dot_b), .dot_start(dot_start),
    .dot_done(dot_done), .dot_c(dot_c),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .err(err), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass = 0;
  logic [15:0] exp_q[$];
  logic [7:0] ref_a[VEC_LEN];
  logic [7:0] ref_b[VEC_LEN];
  int err_cnt = 0;
  int start_cnt = 0;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: dot product of the bytes sent, truncated to the 16-bit result.
  function automatic logic [15:0] ref_dot();
    int unsigned s;
    s = 0;
    for (int i = 0; i < VEC_LEN; i++) s = s + int'(ref_a[i]) * int'(ref_b[i]);
    return s[15:0];
  endfunction

  function automatic logic [255:0] ref_vec(input bit sel_b);
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < VEC_LEN; i++) v[i*8 +: 8] = sel_b ? ref_b[i] : ref_a[i];
    return v;
  endfunction

  // ---------------- engine model ----------------
  // Raises done 3 cycles after start with the product of the staged operands,
  // holds it 2 cycles, then drops it. eng_mute models an engine that never finishes.
  bit eng_mute = 1'b0;
  int eng_cnt = 0;
  int eng_hold = 0;

  function automatic logic [15:0] engine_dot();
    int unsigned s;
    s = 0;
    for (int i = 0; i < VEC_LEN; i++) s = s + int'(dot_a[i]) * int'(dot_b[i]);
    return s[15:0];
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      eng_cnt = 0;
      eng_hold = 0;
      dot_done = 1'b0;
    end else begin
      if (eng_hold > 0) begin
        eng_hold--;
        if (eng_hold == 0) dot_done = 1'b0;
      end
      if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          dot_c = engine_dot();
          dot_done = 1'b1;
          eng_hold = 2;
        end
      end
      if (dot_start && !eng_mute) eng_cnt = 3;
    end
  end

  // Pulse counters for err and dot_start.
  always @(negedge clk) begin
    if (rst_n) begin
      if (err) err_cnt++;
      if (dot_start) start_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    res_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    int guard;
    guard = 0;
    in_valid = 1'b1;
    in_data = d;
    in_last = l;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check_eq("in_ready_wait", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic send_frame(input int nbytes, input int last_at, input int max_gap);
    for (int i = 0; i < nbytes; i++) begin
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
      if (i < VEC_LEN) send_byte(ref_a[i], i == last_at);
      else send_byte(ref_b[i - VEC_LEN], i == last_at);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < VEC_LEN; i++) begin
      ref_a[i] = 8'($urandom_range(0, 255));
      ref_b[i] = 8'($urandom_range(0, 255));
    end
  endtask

  task automatic wait_res(output int cyc);
    cyc = 0;
    while (!res_valid && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    if (!res_valid) check_eq("res_valid_wait", res_valid, 1'b1);
  endtask

  // Wait for the result, compare it, optionally stall with junk on the input
  // port, then complete the handshake and check the one-cycle bubble.
  task automatic take_result(input string tag, input int stall);
    int cyc;
    logic [15:0] exp;
    wait_res(cyc);
    if (exp_q.size() == 0) begin
      check_eq({tag, "_exp_q_empty"}, res_valid, 1'b0);
      exp = 16'h0;
    end else begin
      exp = exp_q.pop_front();
    end
    check_eq({tag, "_data"}, res_data, exp);
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      in_data = 8'($urandom_range(0, 255));
      in_last = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_eq({tag, "_hold_valid"}, res_valid, 1'b1);
      check_eq({tag, "_hold_data"}, res_data, exp);
      check_eq({tag, "_hold_in_ready"}, in_ready, 1'b0);
      check_eq({tag, "_hold_a"}, dot_a, ref_vec(1'b0));
      check_eq({tag, "_hold_b"}, dot_b, ref_vec(1'b1));
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check_eq({tag, "_in_ready_after"}, in_ready, 1'b1);
    check_eq({tag, "_valid_after"}, res_valid, 1'b0);
    check_eq({tag, "_busy_after"}, busy, 1'b0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int s0, e0, cyc, seen;

    // Reset values
    do_reset();
    check_eq("rst_in_ready", in_ready, 1'b1);
    check_eq("rst_res_valid", res_valid, 1'b0);
    check_eq("rst_dot_start", dot_start, 1'b0);
    check_eq("rst_err", err, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_res_data", res_data, 16'h0);
    check_eq("rst_dot_a", dot_a, 256'h0);
    check_eq("rst_dot_b", dot_b, 256'h0);

    // Nominal frame: a=1, b=2 gives 64
    for (int i = 0; i < VEC_LEN; i++) begin
      ref_a[i] = 8'd1;
      ref_b[i] = 8'd2;
    end
    s0 = start_cnt;
    e0 = err_cnt;
    send_frame(NB, NB - 1, 0);
    check_eq("nom_start", dot_start, 1'b1);
    check_eq("nom_busy", busy, 1'b1);
    check_eq("nom_in_ready", in_ready, 1'b0);
    check_eq("nom_dot_a", dot_a, ref_vec(1'b0));
    check_eq("nom_dot_b", dot_b, ref_vec(1'b1));
    exp_q.push_back(ref_dot());
    @(negedge clk);
    check_eq("nom_start_one_cycle", dot_start, 1'b0);
    take_result("nom", 0);
    repeat (2) @(negedge clk);
    check_eq("nom_start_count", start_cnt - s0, 1);
    check_eq("nom_err_count", err_cnt - e0, 0);

    // Backpressure: same frame, consumer stalls 10 cycles
    send_frame(NB, NB - 1, 0);
    exp_q.push_back(ref_dot());
    take_result("bp", 10);

    // Early last on byte 10
    fill_random();
    s0 = start_cnt;
    e0 = err_cnt;
    send_frame(11, 10, 0);
    check_eq("early_err", err, 1'b1);
    check_eq("early_in_ready", in_ready, 1'b1);
    @(negedge clk);
    check_eq("early_err_pulse", err, 1'b0);
    repeat (6) @(negedge clk);
    check_eq("early_no_start", start_cnt - s0, 0);
    check_eq("early_err_count", err_cnt - e0, 1);
    for (int i = 0; i < VEC_LEN; i++) begin
      ref_a[i] = 8'(i);
      ref_b[i] = 8'd1;
    end
    send_frame(NB, NB - 1, 0);
    exp_q.push_back(ref_dot());
    take_result("after_early", 0);

    // Missing last: 64 bytes, in_last never high
    fill_random();
    s0 = start_cnt;
    e0 = err_cnt;
    send_frame(NB, -1, 0);
    check_eq("miss_err", err, 1'b1);
    check_eq("miss_in_ready", in_ready, 1'b1);
    check_eq("miss_busy", busy, 1'b0);
    repeat (6) @(negedge clk);
    check_eq("miss_no_start", start_cnt - s0, 0);
    check_eq("miss_err_count", err_cnt - e0, 1);

    // Random frames with input gaps and consumer stalls
    for (int t = 0; t < 8; t++) begin
      fill_random();
      send_frame(NB, NB - 1, 2);
      check_eq("rnd_start", dot_start, 1'b1);
      exp_q.push_back(ref_dot());
      take_result("rnd", $urandom_range(0, 4));
    end

    // Reset in the middle of a frame: partial frame is lost
    fill_random();
    send_frame(20, -1, 0);
    do_reset();
    check_eq("midrst_in_ready", in_ready, 1'b1);
    check_eq("midrst_dot_a", dot_a, 256'h0);
    fill_random();
    send_frame(NB, NB - 1, 0);
    exp_q.push_back(ref_dot());
    take_result("midrst_frame", 0);

    // Engine never completes
    eng_mute = 1'b1;
    fill_random();
    e0 = err_cnt;
    send_frame(NB, NB - 1, 0);
`ifdef DOT_LOADER_TIMEOUT_EN
    // WAIT occupies 64 cycles after FIRE, so res_valid shows 65 cycles after start.
    wait_res(cyc);
    check_eq("to_latency", cyc, 65);
    check_eq("to_err", err, 1'b1);
    exp_q.push_back(16'h0000);
    take_result("to", 0);
    check_eq("to_err_count", err_cnt - e0, 1);
`else
    seen = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (res_valid) seen++;
    end
    check_eq("no_to_res_valid", seen, 0);
    check_eq("no_to_busy", busy, 1'b1);
    check_eq("no_to_err_count", err_cnt - e0, 0);
    do_reset();
    check_eq("no_to_rst_busy", busy, 1'b0);
    check_eq("no_to_rst_in_ready", in_ready, 1'b1);
`endif
    eng_mute = 1'b0;
    fill_random();
    send_frame(NB, NB - 1, 1);
    exp_q.push_back(ref_dot());
    take_result("final", 1);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time bound
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
